// File: rtl/mac_lane_pipe.sv
// rtl/mac_lane_pipe.sv - two-stage unsigned MAC slice combining 1..LANES lane products
module mac_lane_pipe #(
    parameter int MIN_WIDTH = 8,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = MIN_WIDTH * (LANES + 1) + 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*MIN_WIDTH-1:0] A,
    input  logic [MIN_WIDTH-1:0]       B,
    input  logic [1:0]                 mode,
    input  logic                       acc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_WIDTH-1:0]       C,
    output logic                       ovf
);
    localparam int PW = 2 * MIN_WIDTH;

    logic [PW-1:0]        part_d [LANES];
    logic [PW-1:0]        part_q [LANES];
    logic [1:0]           mode_q;
    logic                 acc_q;
    logic                 s1_valid_q;
    logic                 s1_valid_d;

    logic [ACC_WIDTH-1:0] c_q;
    logic [ACC_WIDTH-1:0] c_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic                 out_valid_q;
    logic                 out_valid_d;

    logic [ACC_WIDTH-1:0] prod;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 s2_load_ok;
    logic                 accept;
    logic                 advance;
    int                   k;

    assign s2_load_ok = !out_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_load_ok;
    assign accept     = in_valid && in_ready;
    assign advance    = s1_valid_q && s2_load_ok;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            part_d[i] = {{MIN_WIDTH{1'b0}}, A[i*MIN_WIDTH +: MIN_WIDTH]} * {{MIN_WIDTH{1'b0}}, B};
        end
    end

    assign s1_valid_d = accept || (s1_valid_q && !advance);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                part_q[i] <= '0;
            end
            mode_q     <= '0;
            acc_q      <= 1'b0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                for (int i = 0; i < LANES; i++) begin
                    part_q[i] <= part_d[i];
                end
                mode_q <= mode;
                acc_q  <= acc;
            end
        end
    end

    // The top k lanes are used; the lowest of them lands at bit 0.
    always_comb begin
        prod = '0;
        k    = 1 << mode_q;
        if (k <= LANES) begin
            for (int i = 0; i < LANES; i++) begin
                if (i >= LANES - k) begin
                    prod = prod + (ACC_WIDTH'(part_q[i]) << (MIN_WIDTH * (i - LANES + k)));
                end
            end
        end
    end

    always_comb begin
        acc_sum     = {1'b0, c_q} + {1'b0, prod};
        c_d         = c_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (advance) begin
            out_valid_d = 1'b1;
            if (acc_q) begin
                c_d   = acc_sum[ACC_WIDTH-1:0];
                ovf_d = ovf_q | acc_sum[ACC_WIDTH];
            end else begin
                c_d   = prod;
                ovf_d = 1'b0;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            c_q         <= c_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign C         = c_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_lane_pipe.sv
// tb/tb_mac_lane_pipe.sv - randomized self-checking bench for mac_lane_pipe
module tb_mac_lane_pipe;
    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  b;
        logic [1:0]  m;
        logic        acc;
    } beat_t;

    typedef struct packed {
        logic [47:0] c;
        logic        o;
    } exp_t;

    localparam longint unsigned MOD = 64'd1 << 48;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_i = '0;
    logic [7:0]  b_i = '0;
    logic [1:0]  mode_i = '0;
    logic        acc_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] c_o;
    logic        ovf;

    int assertions = 0;
    int failures = 0;

    beat_t st_q[$];
    exp_t  exp_q[$];
    longint unsigned m_c = 0;
    logic  m_ovf = 1'b0;

    mac_lane_pipe #(.MIN_WIDTH(8), .LANES(4), .ACC_WIDTH(48)) dut (
        .clk(clk),
        .rst(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(a_i),
        .B(b_i),
        .mode(mode_i),
        .acc(acc_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .C(c_o),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Top k words read as one number, times B.
    function automatic longint unsigned ref_prod(input beat_t bt);
        int k;
        logic [31:0] top;
        k = 1 << bt.m;
        if (k > 4) return 0;
        top = bt.a >> (8 * (4 - k));
        return 64'(top) * 64'(bt.b);
    endfunction

    function automatic void model_apply(input beat_t bt);
        longint unsigned s;
        if (!bt.acc) begin
            m_c   = ref_prod(bt);
            m_ovf = 1'b0;
        end else begin
            s = m_c + ref_prod(bt);
            if (s >= MOD) begin
                m_ovf = 1'b1;
                s = s - MOD;
            end
            m_c = s;
        end
    endfunction

    function automatic beat_t rand_beat();
        beat_t bt;
        bt.a   = $urandom;
        bt.b   = 8'($urandom);
        bt.m   = 2'($urandom);
        bt.acc = 1'($urandom);
        return bt;
    endfunction

    function automatic void note_accept();
        beat_t bt;
        exp_t e;
        bt = st_q.pop_front();
        model_apply(bt);
        e.c = m_c[47:0];
        e.o = m_ovf;
        exp_q.push_back(e);
    endfunction

    task automatic drive_beat(input beat_t bt);
        a_i = bt.a; b_i = bt.b; mode_i = bt.m; acc_i = bt.acc; in_valid = 1'b1;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; a_i = $urandom; b_i = 8'($urandom); mode_i = 2'($urandom); acc_i = 1'($urandom);
    endtask

    task automatic drive_front(input int valid_pct);
        if (st_q.size() > 0 && int'($urandom_range(99)) < valid_pct) drive_beat(st_q[0]);
        else drive_idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b0; drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        assertions++;
        if (out_valid !== 1'b0 || c_o !== 48'h0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_values got out_valid=%0b C=%h ovf=%0b in_ready=%0b exp 0 0 0 1", out_valid, c_o, ovf, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single(input string name, input logic acc_bit);
        beat_t bt;
        bt.a = {8'hFF, 24'($urandom)}; bt.b = 8'hFF; bt.m = 2'b00; bt.acc = acc_bit;
        out_ready = 1'b1;
        drive_beat(bt);
        @(negedge clk);
        assertions++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL %s_in_ready got=%0b exp=1", name, in_ready);
        end
        @(posedge clk); #1;
        drive_idle(); model_apply(bt);
        assertions++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL %s_early_valid got=%0b exp=0", name, out_valid);
        end
        @(posedge clk); #1;
        assertions++;
        if (out_valid !== 1'b1 || c_o !== 48'h00FE01 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL %s_result got valid=%0b C=%h ovf=%0b exp valid=1 C=00fe01 ovf=0", name, out_valid, c_o, ovf);
        end
        @(posedge clk); #1;
        assertions++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL %s_valid_drop got=%0b exp=0", name, out_valid);
        end
    endtask

    task automatic test_modes();
        beat_t       tbl[3];
        logic [47:0] te[3];
        tbl[0] = '{a: {8'h01, 8'h02, 16'($urandom)}, b: 8'h03, m: 2'b01, acc: 1'b0}; te[0] = 48'h0306;
        tbl[1] = '{a: 32'h01020304, b: 8'h02, m: 2'b10, acc: 1'b0};               te[1] = 48'h02040608;
        tbl[2] = '{a: $urandom | 32'h1, b: 8'($urandom) | 8'h1, m: 2'b11, acc: 1'b0}; te[2] = 48'h0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_beat(tbl[i]);
            @(posedge clk); #1;
            drive_idle(); model_apply(tbl[i]);
            @(posedge clk); #1;
            assertions++;
            if (out_valid !== 1'b1 || c_o !== te[i]) begin
                failures++;
                $display("FAIL modes_%0d got valid=%0b C=%h exp valid=1 C=%h", i, out_valid, c_o, te[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_accumulate();
        beat_t       bt[3];
        logic [47:0] te[3];
        for (int i = 0; i < 3; i++) begin
            bt[i] = '{a: {8'd10, 24'($urandom)}, b: 8'd10, m: 2'b00, acc: (i != 0)};
            te[i] = 48'(100 * (i + 1));
        end
        out_ready = 1'b1;
        drive_beat(bt[0]);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            model_apply(bt[i]);
            if (i < 2) drive_beat(bt[i+1]); else drive_idle();
            if (i > 0) begin
                assertions++;
                if (out_valid !== 1'b1 || c_o !== te[i-1] || ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL accum_%0d got valid=%0b C=%0d ovf=%0b exp valid=1 C=%0d ovf=0", i-1, out_valid, c_o, ovf, te[i-1]);
                end
            end
        end
        @(posedge clk); #1;
        assertions++;
        if (out_valid !== 1'b1 || c_o !== te[2] || ovf !== 1'b0) begin
            failures++;
            $display("FAIL accum_2 got valid=%0b C=%0d ovf=%0b exp valid=1 C=%0d ovf=0", out_valid, c_o, ovf, te[2]);
        end
        @(posedge clk); #1;
        assertions++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL accum_drain got valid=%0b exp=0", out_valid);
        end
    endtask

    task automatic test_stream(input string name, input int ready_pct, input int valid_pct, output int cycles);
        int   n;
        int   got;
        exp_t e;
        n = st_q.size() + exp_q.size();
        got = 0;
        cycles = 0;
        out_ready = (int'($urandom_range(99)) < ready_pct);
        drive_front(valid_pct);
        while (got < n && cycles < 30 * n + 200) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got++;
                assertions++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL %s_extra got C=%h exp no result", name, c_o);
                end else begin
                    e = exp_q.pop_front();
                    if (c_o !== e.c || ovf !== e.o) begin
                        failures++;
                        $display("FAIL %s_result got C=%h ovf=%0b exp C=%h ovf=%0b", name, c_o, ovf, e.c, e.o);
                    end
                end
            end
            if (in_valid && in_ready) note_accept();
            @(posedge clk); #1;
            out_ready = (int'($urandom_range(99)) < ready_pct);
            drive_front(valid_pct);
            cycles++;
        end
        assertions++;
        if (got < n) begin
            failures++; $display("FAIL %s_timeout got %0d results exp %0d", name, got, n);
        end
    endtask

    task automatic test_backpressure();
        int   cycles;
        logic exp_rdy;
        for (int i = 0; i < 4; i++) st_q.push_back(rand_beat());
        out_ready = 1'b0;
        drive_front(100);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_rdy = (c < 2) ? 1'b1 : 1'b0;
            assertions++;
            if (in_ready !== exp_rdy) begin
                failures++; $display("FAIL bp_in_ready_c%0d got=%0b exp=%0b", c, in_ready, exp_rdy);
            end
            if (c >= 2) begin
                assertions++;
                if (out_valid !== 1'b1 || c_o !== exp_q[0].c || ovf !== exp_q[0].o) begin
                    failures++;
                    $display("FAIL bp_hold_c%0d got valid=%0b C=%h ovf=%0b exp valid=1 C=%h ovf=%0b", c, out_valid, c_o, ovf, exp_q[0].c, exp_q[0].o);
                end
            end
            if (in_valid && in_ready) note_accept();
            @(posedge clk); #1;
            drive_front(100);
        end
        test_stream("bp_drain", 100, 100, cycles);
    endtask

    task automatic test_back_to_back();
        int cycles;
        int n;
        n = 20;
        for (int i = 0; i < n; i++) st_q.push_back(rand_beat());
        test_stream("b2b", 100, 100, cycles);
        assertions++;
        if (cycles !== n + 2) begin
            failures++; $display("FAIL b2b_throughput got %0d cycles exp %0d", cycles, n + 2);
        end
    endtask

    task automatic test_random();
        int cycles;
        for (int i = 0; i < 200; i++) st_q.push_back(rand_beat());
        test_stream("random", 60, 70, cycles);
    endtask

    task automatic test_overflow();
        int    cycles;
        beat_t bt;
        bt = '{a: 32'hFFFFFFFF, b: 8'hFF, m: 2'b10, acc: 1'b0};
        st_q.push_back(bt);
        bt.acc = 1'b1;
        repeat (260) st_q.push_back(bt);
        test_stream("ovf_wrap", 80, 90, cycles);
        assertions++;
        if (ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_set got=%0b exp=1", ovf);
        end
        bt.acc = 1'b0;
        st_q.push_back(bt);
        test_stream("ovf_clear", 100, 100, cycles);
        assertions++;
        if (ovf !== 1'b0 || c_o !== 48'hFEFFFFFF01) begin
            failures++; $display("FAIL ovf_clear_final got ovf=%0b C=%h exp ovf=0 C=fefffffF01", ovf, c_o);
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 2; i++) st_q.push_back('{a: $urandom | 32'h01000000, b: 8'($urandom) | 8'h1, m: 2'b10, acc: 1'b0});
        out_ready = 1'b0;
        drive_front(100);
        for (int c = 0; c < 10 && st_q.size() > 0; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) note_accept();
            @(posedge clk); #1;
            drive_front(100);
        end
        assertions++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++; $display("FAIL rst_fill got in_ready=%0b out_valid=%0b exp 0 1", in_ready, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        assertions++;
        if (out_valid !== 1'b0 || c_o !== 48'h0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_async got out_valid=%0b C=%h ovf=%0b in_ready=%0b exp 0 0 0 1", out_valid, c_o, ovf, in_ready);
        end
        st_q.delete(); exp_q.delete(); m_c = 0; m_ovf = 1'b0;
        drive_idle();
        @(posedge clk); #1;
        assertions++;
        if (out_valid !== 1'b0 || c_o !== 48'h0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_held got out_valid=%0b C=%h in_ready=%0b exp 0 0 1", out_valid, c_o, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_single("post_reset", 1'b1);
    endtask

    initial begin
        test_reset();
        test_single("single", 1'b0);
        test_modes();
        test_accumulate();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_overflow();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
